motion_ctrl: RTL

Parametrised successor to the single-purpose movement and engine FSMs. One block tracks lane position and speed level for the project vehicle from four push-button inputs, and drives an alarm on hazard. Lane count and speed levels are set by parameters; inputs are edge-detected and values saturate. It sits between the debounced button inputs and the display/motor drivers.

---
 rtl/motion_pkg.sv | 7 +
 rtl/motion_ctrl_edge_detect.sv | 15 +
 rtl/motion_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// motion_pkg: FSM state type and width helper shared by motion_ctrl and its tests.
package motion_pkg;
   typedef enum logic [1:0] {IDLE, ALARM, HOLD} state_e;
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/motion_ctrl_edge_detect.sv
// edge_detect: one-cycle pulse on a 0->1 transition; history resets to 1 so a
// level held through reset release never fires.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic hist_d, hist_q;
   always_comb hist_d = d;
   always_ff @(posedge clk or negedge reset)
      if (!reset) hist_q <= 1'b1;
      else        hist_q <= hist_d;
   assign rise = d & ~hist_q;
endmodule

// File: rtl/motion_ctrl.sv
// motion_ctrl: lane position / speed level tracker with hazard alarm FSM.
// Define MOTION_WRAP_EN to make position wrap instead of saturate.
module motion_ctrl
   import motion_pkg::*;
#(
   parameter int LANES        = 8,
   parameter int SPEEDS       = 4,
   parameter int ALARM_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          l_in,
   input  logic                          r_in,
   input  logic                          b_in,
   input  logic                          f_in,
   input  logic                          hazard_in,
   output logic [width_of(LANES)-1:0]    pos_out,
   output logic [width_of(SPEEDS)-1:0]   speed_out,
   output logic                          alarm_out
);
   localparam int PW = width_of(LANES);
   localparam int SW = width_of(SPEEDS);
   localparam int CW = width_of(ALARM_CYCLES);
   localparam logic [PW-1:0] POS_MAX  = PW'(LANES - 1);
   localparam logic [PW-1:0] POS_RST  = PW'(LANES / 2);
   localparam logic [SW-1:0] SPD_MAX  = SW'(SPEEDS - 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(ALARM_CYCLES - 1);
`ifdef MOTION_WRAP_EN
   localparam logic [PW-1:0] POS_UNDER = POS_MAX;
   localparam logic [PW-1:0] POS_OVER  = '0;
`else
   localparam logic [PW-1:0] POS_UNDER = '0;
   localparam logic [PW-1:0] POS_OVER  = POS_MAX;
`endif

   logic l_ev, r_ev, b_ev, f_ev;
   edge_detect u_l (.clk(clk), .reset(reset), .d(l_in), .rise(l_ev));
   edge_detect u_r (.clk(clk), .reset(reset), .d(r_in), .rise(r_ev));
   edge_detect u_b (.clk(clk), .reset(reset), .d(b_in), .rise(b_ev));
   edge_detect u_f (.clk(clk), .reset(reset), .d(f_in), .rise(f_ev));

   state_e          state_d, state_q;
   logic [PW-1:0]   pos_d, pos_q;
   logic [SW-1:0]   spd_d, spd_q;
   logic [CW-1:0]   cnt_d, cnt_q;
   logic            alarm_d, alarm_q;

   // position steers in every state so the vehicle can dodge during an alarm
   always_comb begin
      pos_d = pos_q;
      if (l_ev && !r_ev) pos_d = (pos_q == '0) ? POS_UNDER : pos_q - PW'(1);
      if (r_ev && !l_ev) pos_d = (pos_q == POS_MAX) ? POS_OVER : pos_q + PW'(1);
   end

   always_comb begin
      state_d = state_q;
      spd_d   = spd_q;
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
      case (state_q)
         IDLE:
            if (hazard_in && spd_q != '0) begin
               state_d = ALARM;
               spd_d   = '0;
               alarm_d = 1'b1;
               cnt_d   = CNT_INIT;
            end else if (f_ev && !b_ev && spd_q != SPD_MAX) spd_d = spd_q + SW'(1);
            else if (b_ev && !f_ev && spd_q != '0) spd_d = spd_q - SW'(1);
         ALARM:
            if (cnt_q == '0) begin
               alarm_d = 1'b0;
               state_d = hazard_in ? HOLD : IDLE;
            end else cnt_d = cnt_q - CW'(1);
         HOLD: begin
            spd_d = '0;
            if (!hazard_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         pos_q   <= POS_RST;
         spd_q   <= '0;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         spd_q   <= spd_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
      end

   assign pos_out   = pos_q;
   assign speed_out = spd_q;
   assign alarm_out = alarm_q;
endmodule
